// File: rtl/backbone_pkg.sv
// rtl/backbone_pkg.sv - shared widths, conv shape type, engine states and output-size helper
package backbone_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  typedef struct packed {
    int cin;
    int h;
    int w;
    int cout;
    int kh;
    int kw;
    int stride;
    int pad;
  } conv_shape_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_OUT,
    S_DONE
  } eng_state_t;

  function automatic int out_dim(input int in_dim, input int k, input int stride, input int pad);
    return (in_dim + 2 * pad - k) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// rtl/conv_mac_lane.sv - single-lane signed multiply-accumulate with clear/enable, wrapping at ACC_W
module conv_mac_lane #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc_nx
);

  logic signed [ACC_W-1:0]    acc;
  logic signed [2*DATA_W-1:0] prod;

  assign prod   = a * b;
  // acc_nx already includes the tap landing this cycle so the engine can capture it in DRAIN
  assign acc_nx = en ? acc + ACC_W'(prod) : acc;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else begin
      acc <= acc_nx;
    end
  end

endmodule

// File: rtl/conv_gemm_stream_engine.sv
// rtl/conv_gemm_stream_engine.sv - parametrised conv engine: SRAM read ports in, PE_N-lane beats out
// Define CONV_RELU_EN to clamp negative lanes to 0 when loaded into the output register.
module conv_gemm_stream_engine
  import backbone_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CIN    = 3,
  parameter int H_IN   = 112,
  parameter int W_IN   = 112,
  parameter int COUT   = 64,
  parameter int KH     = 7,
  parameter int KW     = 7,
  parameter int STRIDE = 2,
  parameter int PAD    = 3,
  parameter int PE_N   = 8,
  localparam int H_OUT = out_dim(H_IN, KH, STRIDE, PAD),
  localparam int W_OUT = out_dim(W_IN, KW, STRIDE, PAD),
  localparam int NCB   = COUT / PE_N,
  localparam int FA_W  = $clog2(CIN * H_IN * W_IN),
  localparam int WA_W  = $clog2(NCB * CIN * KH * KW),
  localparam int CB_W  = $clog2(NCB) + 1,
  localparam int OH_W  = $clog2(H_OUT) + 1,
  localparam int OW_W  = $clog2(W_OUT) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     fmap_rd_en,
  output logic [FA_W-1:0]          fmap_addr,
  input  logic signed [DATA_W-1:0] fmap_rdata,
  output logic                     w_rd_en,
  output logic [WA_W-1:0]          w_addr,
  input  logic [PE_N*DATA_W-1:0]   w_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PE_N*ACC_W-1:0]    out_data,
  output logic [CB_W-1:0]          out_cb,
  output logic [OH_W-1:0]          out_oh,
  output logic [OW_W-1:0]          out_ow
);

  localparam int CI_W = $clog2(CIN) + 1;
  localparam int KH_W = $clog2(KH) + 1;
  localparam int KW_W = $clog2(KW) + 1;
  localparam conv_shape_t SHAPE = '{CIN, H_IN, W_IN, COUT, KH, KW, STRIDE, PAD};

  if (COUT % PE_N != 0) begin : g_cout_chk
    $error("conv_gemm_stream_engine: COUT must be a multiple of PE_N");
  end

  eng_state_t state;
  logic [CB_W-1:0] cb;
  logic [OH_W-1:0] oh;
  logic [OW_W-1:0] ow;
  logic [CI_W-1:0] ci;
  logic [KH_W-1:0] kh;
  logic [KW_W-1:0] kw;
  logic tap_v, tap_pad;
  logic pad_tap, first_tap, last_pix;
  int ih, iw;
  logic signed [DATA_W-1:0] tap_a;
  logic [PE_N*ACC_W-1:0] lane_res;

  always_comb begin
    ih         = int'(oh) * STRIDE + int'(kh) - PAD;
    iw         = int'(ow) * STRIDE + int'(kw) - PAD;
    pad_tap    = (ih < 0) || (ih >= SHAPE.h) || (iw < 0) || (iw >= SHAPE.w);
    first_tap  = (state == S_ISSUE) && (ci == '0) && (kh == '0) && (kw == '0);
    last_pix   = (cb == CB_W'(NCB - 1)) && (oh == OH_W'(H_OUT - 1)) && (ow == OW_W'(W_OUT - 1));
    fmap_rd_en = (state == S_ISSUE) && !pad_tap;
    w_rd_en    = (state == S_ISSUE);
    fmap_addr  = pad_tap ? '0 : FA_W'(int'(ci) * SHAPE.h * SHAPE.w + ih * SHAPE.w + iw);
    w_addr     = WA_W'(((int'(cb) * CIN + int'(ci)) * KH + int'(kh)) * KW + int'(kw));
    tap_a      = tap_pad ? '0 : fmap_rdata;
  end

  for (genvar l = 0; l < PE_N; l++) begin : g_lane
    logic signed [ACC_W-1:0] acc_nx;

    conv_mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
      .clk    (clk),
      .rst    (rst),
      .clr    (first_tap),
      .en     (tap_v),
      .a      (tap_a),
      .b      (w_rdata[l*DATA_W +: DATA_W]),
      .acc_nx (acc_nx)
    );

`ifdef CONV_RELU_EN
    assign lane_res[l*ACC_W +: ACC_W] = acc_nx[ACC_W-1] ? '0 : acc_nx;
`else
    assign lane_res[l*ACC_W +: ACC_W] = acc_nx;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cb        <= '0;
      oh        <= '0;
      ow        <= '0;
      ci        <= '0;
      kh        <= '0;
      kw        <= '0;
      tap_v     <= 1'b0;
      tap_pad   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cb    <= '0;
      out_oh    <= '0;
      out_ow    <= '0;
    end else begin
      tap_v   <= (state == S_ISSUE);
      tap_pad <= (state == S_ISSUE) && pad_tap;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_ISSUE;
            busy  <= 1'b1;
            done  <= 1'b0;
            cb    <= '0;
            oh    <= '0;
            ow    <= '0;
            ci    <= '0;
            kh    <= '0;
            kw    <= '0;
          end
        end
        S_ISSUE: begin
          if (kw == KW_W'(KW - 1)) begin
            kw <= '0;
            if (kh == KH_W'(KH - 1)) begin
              kh <= '0;
              if (ci == CI_W'(CIN - 1)) begin
                ci    <= '0;
                state <= S_DRAIN;
              end else begin
                ci <= ci + 1'b1;
              end
            end else begin
              kh <= kh + 1'b1;
            end
          end else begin
            kw <= kw + 1'b1;
          end
        end
        S_DRAIN: begin
          out_data  <= lane_res;
          out_cb    <= cb;
          out_oh    <= oh;
          out_ow    <= ow;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_pix) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_ISSUE;
              if (ow == OW_W'(W_OUT - 1)) begin
                ow <= '0;
                if (oh == OH_W'(H_OUT - 1)) begin
                  oh <= '0;
                  cb <= cb + 1'b1;
                end else begin
                  oh <= oh + 1'b1;
                end
              end else begin
                ow <= ow + 1'b1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_gemm_stream_engine.md
Name: conv_gemm_stream_engine

Overview:
Parametrised successor to the full-array conv1 GEMM top. It computes a 2-D convolution of any size (CIN/H/W/COUT/K/stride/pad) instead of being fixed to conv1 shapes. It reads fmap and weights through synchronous memory read ports rather than whole-array ports. PE_N output channels are computed in parallel per pixel, and results are emitted on a valid/ready output stream. It sits between the backbone's fmap/weight SRAMs and the layer-output writer.

Parameters:
- DATA_W, 8: signed activation/weight width.
- ACC_W, 32: signed accumulator/output width.
- CIN, 3: input channels.
- H_IN, 112: input height.
- W_IN, 112: input width.
- COUT, 64: output channels; must be a multiple of PE_N (elaboration $error otherwise).
- KH, 7: kernel height.
- KW, 7: kernel width.
- STRIDE, 2: spatial stride, ≥1.
- PAD, 3: zero padding on every edge.
- PE_N, 8: output-channel lanes computed in parallel.
- Derived localparams: H_OUT=(H_IN+2*PAD-KH)/STRIDE+1; W_OUT likewise; FA_W=$clog2(CIN*H_IN*W_IN); WA_W=$clog2((COUT/PE_N)*CIN*KH*KW).

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- start, in, 1: one-cycle launch; ignored unless the FSM is in IDLE or DONE.
- busy, out, 1: high from the cycle after an accepted start until DONE.
- done, out, 1: sticky; high in DONE until the next accepted start or rst.
- fmap_rd_en, out, 1: fmap read strobe.
- fmap_addr, out, FA_W: address = ci*H_IN*W_IN + ih*W_IN + iw.
- fmap_rdata, in, DATA_W: signed; valid exactly 1 cycle after fmap_rd_en.
- w_rd_en, out, 1: weight read strobe.
- w_addr, out, WA_W: address = ((cb*CIN+ci)*KH+kh)*KW+kw.
- w_rdata, in, PE_N*DATA_W: lane l (bits l*DATA_W +: DATA_W) holds the weight for co = cb*PE_N+l; 1-cycle latency.
- out_valid, out, 1: output beat valid.
- out_ready, in, 1: downstream accepts the beat.
- out_data, out, PE_N*ACC_W: lane l holds out[cb*PE_N+l][oh][ow].
- out_cb, out, $clog2(COUT/PE_N)+1: channel-block index.
- out_oh, out, $clog2(H_OUT)+1: output row.
- out_ow, out, $clog2(W_OUT)+1: output column.

Behaviour:
- Reset: FSM to IDLE; all counters, accumulators, busy, done, out_valid, fmap_rd_en and w_rd_en go to 0. Takes effect mid-operation as well; any in-flight read data is discarded.
- FSM states: IDLE → (start) ISSUE → DRAIN → OUT → ISSUE (next pixel) or DONE; DONE → (start) ISSUE.
- Loop order, outermost first: cb, oh, ow (pixel loop), then ci, kh, kw (reduction loop).
- ISSUE: one tap per cycle, K=CIN*KH*KW cycles per pixel.
  - ih = oh*STRIDE+kh-PAD and iw = ow*STRIDE+kw-PAD, signed.
  - If ih/iw is out of range: fmap_rd_en=0, and a pad flag is pipelined alongside the read; the tap contributes 0.
  - w_rd_en is always 1 in ISSUE.
- Read pipeline: registered valid/pad flag, 1 stage. The MAC updates on the cycle after each issue.
  - acc[l] += sext(fmap)*sext(w[l]), products sign-extended to ACC_W.
  - Arithmetic wraps modulo 2^ACC_W; no saturation.
  - Accumulators are cleared when the first tap of a pixel is issued.
- DRAIN: 1 cycle for the last MAC; the result is then loaded into the output register.
- OUT: out_valid=1. out_data, out_cb, out_oh and out_ow stay stable until out_valid&&out_ready. Backpressure stalls the engine indefinitely.
- Per-pixel latency with out_ready held high: K+2 cycles. Total cycles ≈ (COUT/PE_N)*H_OUT*W_OUT*(K+2).
- After the last beat (cb, oh, ow all at their final values) is accepted: go to DONE; busy falls and done rises in the same cycle.
- A start while busy is ignored. Start in DONE clears done and relaunches.

Optional Feature:
- CONV_RELU_EN: when defined, each output lane is clamped to 0 if negative when loaded into the output register; the accumulator itself is unaffected.
- Without it, raw wrapped signed sums are emitted.

Decomposition:
- backbone_pkg: DATA_W/ACC_W defaults, a conv_shape_t struct (cin, h, w, cout, kh, kw, stride, pad), and an out_dim() constant function.
- One sub-module, conv_mac_lane: a single-lane signed MAC with clear/enable. The engine instantiates it PE_N times in a generate loop.

Test Plan:
- Ones test, CIN=1, H=W=4, K=3, S=1, P=1, COUT=PE_N=2, all fmap/weights = 1 → both lanes give 4 at corners, 6 at edges, 9 at the interior; 16 beats; done sticky.
- Full conv1 shape (defaults) on 5 random cases from conv1_cases/ → every out[co][oh][ow] matches golden and beat order is cb, oh, ow.
- Backpressure: out_ready low for 5 cycles on beat 3 → out_valid stays high, out_data/out_oh/out_ow stable, no beat lost or duplicated.
- Wrap: DATA_W=8, ACC_W=16, K=3, P=0, all values -128 → each output = 147456 mod 65536 = 16384.
- ReLU: weights all -1, fmap all 1, 3×3, P=0 → output 0 with CONV_RELU_EN, -9 without.
- Reset mid-op: rst asserted during ISSUE of pixel 5 → next cycle busy=0, out_valid=0, done=0. A new start reruns from pixel (0,0,0) with correct results.
